// File: rtl/control_cabina.sv
// Elevator cabin controller: takes the next request code, moves the cabin between
// four floors one floor per T_PISO cycles, then runs a door cycle of T_PUERTA cycles.
module control_cabina #(
  parameter int T_PISO   = 50_000_000,
  parameter int T_PUERTA = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] memoria,
  input  logic       obstaculo,
  output logic [1:0] piso,
  output logic [1:0] accion,
  output logic       listo
);

  localparam int T_MAX = (T_PISO > T_PUERTA) ? T_PISO : T_PUERTA;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] PISO_FIN   = TMR_W'(T_PISO - 1);
  localparam logic [TMR_W-1:0] PUERTA_FIN = TMR_W'(T_PUERTA - 1);

  // State encoding doubles as the accion code, so accion is simply the state register.
  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    SUBIENDO = 2'b01,
    BAJANDO  = 2'b10,
    PUERTA   = 2'b11
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [1:0]       piso_q, piso_d;
  logic [1:0]       destino_q, destino_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             listo_q, listo_d;

  logic             pedido_ok;
  logic [1:0]       pedido_piso;
  logic [1:0]       piso_paso;

  always_comb begin
    pedido_ok   = (memoria >= 4'd1) && (memoria <= 4'd4);
    pedido_piso = 2'(memoria - 4'd1);
    piso_paso   = piso_q;
    if (estado_q == SUBIENDO && piso_q != 2'd3) begin
      piso_paso = piso_q + 2'd1;
    end else if (estado_q == BAJANDO && piso_q != 2'd0) begin
      piso_paso = piso_q - 2'd1;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    piso_d    = piso_q;
    destino_d = destino_q;
    timer_d   = timer_q;
    listo_d   = 1'b0;
    case (estado_q)
      REPOSO: begin
        timer_d = '0;
        // The listo cycle is skipped so the memory stage has one cycle to advance.
        if (pedido_ok && !listo_q) begin
          destino_d = pedido_piso;
          if (pedido_piso > piso_q) begin
            estado_d = SUBIENDO;
          end else if (pedido_piso < piso_q) begin
            estado_d = BAJANDO;
          end else begin
            estado_d = PUERTA;
          end
        end
      end
      SUBIENDO, BAJANDO: begin
        if (timer_q >= PISO_FIN) begin
          timer_d = '0;
          piso_d  = piso_paso;
          // A blocked step at the shaft limit also opens the door rather than stalling.
          if (piso_paso == destino_q || piso_paso == piso_q) begin
            estado_d = PUERTA;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PUERTA: begin
        if (obstaculo) begin
          timer_d = '0;
        end else if (timer_q >= PUERTA_FIN) begin
          timer_d  = '0;
          estado_d = REPOSO;
          listo_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        estado_d = REPOSO;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      piso_q    <= 2'd0;
      destino_q <= 2'd0;
      timer_q   <= '0;
      listo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      piso_q    <= piso_d;
      destino_q <= destino_d;
      timer_q   <= timer_d;
      listo_q   <= listo_d;
    end
  end

  assign piso   = piso_q;
  assign accion = estado_q;
  assign listo  = listo_q;

endmodule

// File: tb/tb_control_cabina.sv
// Bench for control_cabina with short travel/door times; expected per-cycle
// {piso, accion, listo} tuples are queued with the stimulus and popped each cycle.
module tb_control_cabina;

  localparam int T_PISO   = 4;
  localparam int T_PUERTA = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] memoria;
  logic       obstaculo;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       listo;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  logic [4:0] e;

  control_cabina #(.T_PISO(T_PISO), .T_PUERTA(T_PUERTA)) dut (
    .clk(clk),
    .reset(reset),
    .memoria(memoria),
    .obstaculo(obstaculo),
    .piso(piso),
    .accion(accion),
    .listo(listo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(input logic [1:0] p, input logic [1:0] a, input logic l);
    exp_q.push_back({p, a, l});
  endfunction

  // Full request: travel floor by floor, door cycle, listo pulse, one idle cycle.
  function automatic void push_trip(input int from, input int to);
    int cur;
    logic [1:0] dir;
    cur = from;
    dir = (to > from) ? 2'b01 : 2'b10;
    while (cur != to) begin
      for (int k = 0; k < T_PISO; k++) push_exp(2'(cur), dir, 1'b0);
      cur = (to > from) ? cur + 1 : cur - 1;
    end
    for (int k = 0; k < T_PUERTA; k++) push_exp(2'(to), 2'b11, 1'b0);
    push_exp(2'(to), 2'b00, 1'b1);
    push_exp(2'(to), 2'b00, 1'b0);
  endfunction

  task automatic test_reset();
    reset = 1'b1; memoria = 4'd0; obstaculo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (piso !== 2'd0)   begin errors++; $display("FAIL reset_piso: got %0d expected 0", piso); end
    checks++; if (accion !== 2'd0) begin errors++; $display("FAIL reset_accion: got %0d expected 0", accion); end
    checks++; if (listo !== 1'b0)  begin errors++; $display("FAIL reset_listo: got %0d expected 0", listo); end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) push_exp(2'd0, 2'b00, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL idle[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_subir();
    memoria = 4'd4;
    push_trip(0, 3);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 0) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL subir[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_bajar();
    memoria = 4'd2;
    push_trip(3, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 0) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL bajar[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_mismo_piso();
    memoria = 4'd2;
    push_trip(1, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 0) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL mismo_piso[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_obstaculo();
    memoria = 4'd2;
    // Obstacle on the 2nd door cycle restarts the count: 2 + T_PUERTA door cycles.
    for (int k = 0; k < 2 + T_PUERTA; k++) push_exp(2'd1, 2'b11, 1'b0);
    push_exp(2'd1, 2'b00, 1'b1);
    push_exp(2'd1, 2'b00, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 0) memoria = 4'd0;
      if (i == 1) obstaculo = 1'b1;
      if (i == 2) obstaculo = 1'b0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL obstaculo[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_invalido();
    memoria = 4'd5;
    for (int k = 0; k < 8; k++) push_exp(2'd1, 2'b00, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 3) memoria = 4'd15;
      if (i == 6) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL invalido[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_cambio_en_marcha();
    memoria = 4'd1;
    push_trip(1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 0) memoria = 4'd3;
      if (i == 2) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL cambio[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Request held through listo: re-sampled only on the cycle after listo.
    memoria = 4'd1;
    push_trip(0, 0);
    push_trip(0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == T_PUERTA + 2) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_en_marcha();
    memoria = 4'd4;
    for (int k = 0; k < T_PISO; k++) push_exp(2'd0, 2'b01, 1'b0);
    push_exp(2'd1, 2'b01, 1'b0);
    push_exp(2'd1, 2'b01, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      if (i == 0) memoria = 4'd0;
      e = exp_q.pop_front(); checks++;
      if ({piso, accion, listo} !== e) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d]: got piso=%0d accion=%0d listo=%0d expected piso=%0d accion=%0d listo=%0d",
                 i, piso, accion, listo, e[4:3], e[2:1], e[0]);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (piso !== 2'd0)   begin errors++; $display("FAIL reset_mid_piso: got %0d expected 0", piso); end
    checks++; if (accion !== 2'd0) begin errors++; $display("FAIL reset_mid_accion: got %0d expected 0", accion); end
    checks++; if (listo !== 1'b0)  begin errors++; $display("FAIL reset_mid_listo: got %0d expected 0", listo); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({piso, accion, listo} !== 5'b00_00_0) begin
        errors++;
        $display("FAIL reset_mid_idle: got piso=%0d accion=%0d listo=%0d expected 0 0 0", piso, accion, listo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_subir();
    test_bajar();
    test_mismo_piso();
    test_obstaculo();
    test_invalido();
    test_cambio_en_marcha();
    test_back_to_back();
    test_reset_en_marcha();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
